// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC sequencer and its four-lane
// int8 product-sum datapath.
package mac_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned LEN_W_DEF  = 12;
    localparam int unsigned LANE_W     = 8;
    localparam int unsigned OFF_W      = 9;
    localparam int unsigned LANES      = 4;
    localparam int unsigned WORD_W     = LANE_W * LANES;
    localparam int unsigned PROD_W     = 2 * OFF_W;
    localparam int unsigned ACC_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RESP
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Command, buffer-read and response signals of the MAC sequencer.
interface mac_seq_ctrl_if
    import mac_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
);

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_W-1:0]        cmd_in_base;
    logic [ADDR_W-1:0]        cmd_flt_base;
    logic [LEN_W-1:0]         cmd_len;
    logic [OFF_W-1:0]         cmd_input_offset;
    logic [OFF_W-1:0]         cmd_filter_offset;

    logic                     rd_en;
    logic [ADDR_W-1:0]        in_addr;
    logic [ADDR_W-1:0]        flt_addr;
    logic [WORD_W-1:0]        in_rdata;
    logic [WORD_W-1:0]        flt_rdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ACC_W-1:0]         rsp_acc;
    logic                     busy;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_in_base, cmd_flt_base, cmd_len,
               cmd_input_offset, cmd_filter_offset,
               in_rdata, flt_rdata, rsp_ready,
        output cmd_ready, rd_en, in_addr, flt_addr,
               rsp_valid, rsp_acc, busy
    );

    // Command issuer, buffers and response consumer side.
    modport master (
        output cmd_valid, cmd_in_base, cmd_flt_base, cmd_len,
               cmd_input_offset, cmd_filter_offset,
               in_rdata, flt_rdata, rsp_ready,
        input  cmd_ready, rd_en, in_addr, flt_addr,
               rsp_valid, rsp_acc, busy
    );

endinterface

// File: rtl/mac_seq_ctrl_simd_mac4.sv
// Combinational four-lane int8 product sum with per-operand offsets;
// shared with the datapath CFU.
module simd_mac4
    import mac_seq_pkg::*;
(
    input  logic [WORD_W-1:0]        act_word,
    input  logic [WORD_W-1:0]        flt_word,
    input  logic signed [OFF_W-1:0]  act_off,
    input  logic signed [OFF_W-1:0]  flt_off,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [OFF_W-1:0]  act_op;
    logic signed [OFF_W-1:0]  flt_op;
    logic signed [PROD_W-1:0] prod;

    // Operands stay 9-bit signed; the 18-bit product is exact.
    always_comb begin
        sum    = '0;
        act_op = '0;
        flt_op = '0;
        prod   = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            act_op = $signed({act_word[LANE_W*k + LANE_W - 1], act_word[LANE_W*k +: LANE_W]}) + act_off;
            flt_op = $signed({flt_word[LANE_W*k + LANE_W - 1], flt_word[LANE_W*k +: LANE_W]}) + flt_off;
            prod   = act_op * flt_op;
            sum    = sum + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: streams word pairs from the input and filter
// buffers and accumulates offset-corrected four-lane products.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
)(
    input  logic          clk,
    input  logic          reset,
    mac_seq_ctrl_if.slave bus
);

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]        in_base;
    logic [ADDR_W-1:0]        flt_base;
    logic [LEN_W-1:0]         len;
    logic signed [OFF_W-1:0]  in_off;
    logic signed [OFF_W-1:0]  flt_off;
    logic [LEN_W-1:0]         idx;
    logic [ACC_W-1:0]         acc;
    logic                     data_valid;

    logic                     rd_en;
    logic                     cmd_ready;
    logic                     rsp_valid;
    logic                     last_read;
    logic signed [ACC_W-1:0]  lane_sum;

    simd_mac4 u_mac (
        .act_word (bus.in_rdata),
        .flt_word (bus.flt_rdata),
        .act_off  (in_off),
        .flt_off  (flt_off),
        .sum      (lane_sum)
    );

    assign last_read = (idx == len - LEN_W'(1));

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = (bus.cmd_len != '0) ? READ : RESP;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (last_read) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_base    <= '0;
            flt_base   <= '0;
            len        <= '0;
            in_off     <= '0;
            flt_off    <= '0;
            idx        <= '0;
            acc        <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_next;
            data_valid <= rd_en;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        in_base  <= bus.cmd_in_base;
                        flt_base <= bus.cmd_flt_base;
                        len      <= bus.cmd_len;
                        in_off   <= bus.cmd_input_offset;
                        flt_off  <= bus.cmd_filter_offset;
                        idx      <= '0;
                        acc      <= '0;
                    end
                end
                READ: begin
                    idx <= idx + LEN_W'(1);
                end
                default: begin
                end
            endcase
            // Read data arrives one cycle after the strobe; data_valid is
            // never set in IDLE, so it cannot collide with the acc clear.
            if (data_valid) begin
                acc <= acc + lane_sum;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rd_en     = rd_en;
    assign bus.in_addr   = rd_en ? (in_base + ADDR_W'(idx)) : '0;
    assign bus.flt_addr  = rd_en ? (flt_base + ADDR_W'(idx)) : '0;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_acc   = acc;
    assign bus.busy      = (state != IDLE);

endmodule
